// File: rtl/uart_avalon_master.sv
// Avalon-MM master for the UART FIFO peripheral.
// Polls status, drains RX into a holding reg, pushes TX bytes and starts them.
module uart_avalon_master #(
   parameter int P        = 0,
   parameter int POLL_GAP = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [8+P-1:0] tx_data,
   input  logic          tx_valid,
   output logic          tx_ready,
   output logic [8+P-1:0] rx_data,
   output logic          rx_valid,
   input  logic          rx_ready,
   output logic [1:0]    address,
   output logic          chipselect,
   output logic          read,
   output logic          write,
   output logic [31:0]   writedata,
   input  logic [31:0]   readdata
);

   localparam int DW   = 8 + P;
   localparam int CW   = $clog2(POLL_GAP + 1);
   localparam int LOADV = (POLL_GAP > 1) ? POLL_GAP - 2 : 0;

   typedef enum logic [3:0] {
      IDLE, POLL, POLL_WAIT, DECIDE,
      RD_DATA, RD_WAIT, POP_SET, POP_CLR,
      TX_DATA, PUSH_SET, PUSH_CLR,
      START_SET, START_CLR, GAP, WAIT
   } state_t;

   state_t state, state_n, ret, ret_n;

   logic [3:0]    status;
   logic          tx_pending;
   logic [CW-1:0] cnt;
   logic          rx_go, tx_go, st_go;
   logic          unused_bits;

   assign unused_bits = ^readdata[31:DW];

   // status: [0] full_tx [1] empty_tx [2] full_rx [3] empty_rx
   assign rx_go = !status[3] && !rx_valid;
   assign tx_go = tx_valid && !status[0];
   assign st_go = tx_pending && (!tx_valid || status[0]);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ret   <= IDLE;
      end else begin
         state <= state_n;
         ret   <= ret_n;
      end
   end

   always_comb begin
      state_n    = state;
      ret_n      = ret;
      address    = 2'd0;
      chipselect = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
      writedata  = 32'd0;
      tx_ready   = 1'b0;
      unique case (state)
         IDLE: state_n = POLL;
         POLL: begin
            chipselect = 1'b1;
            read       = 1'b1;
            address    = 2'd2;
            state_n    = POLL_WAIT;
         end
         POLL_WAIT: state_n = DECIDE;
         DECIDE: begin
            if (rx_go)              state_n = RD_DATA;
            else if (tx_go)         state_n = TX_DATA;
            else if (st_go)         state_n = START_SET;
            else if (POLL_GAP > 1)  state_n = WAIT;
            else                    state_n = IDLE;
         end
         RD_DATA: begin
            chipselect = 1'b1;
            read       = 1'b1;
            address    = 2'd1;
            state_n    = RD_WAIT;
         end
         RD_WAIT: state_n = POP_SET;
         POP_SET: begin
            chipselect = 1'b1;
            write      = 1'b1;
            address    = 2'd3;
            writedata  = 32'h4;
            state_n    = GAP;
            ret_n      = POP_CLR;
         end
         POP_CLR: begin
            chipselect = 1'b1;
            write      = 1'b1;
            address    = 2'd3;
            state_n    = GAP;
            ret_n      = IDLE;
         end
         TX_DATA: begin
            chipselect = 1'b1;
            write      = 1'b1;
            address    = 2'd0;
            writedata  = 32'(tx_data);
            tx_ready   = 1'b1;
            state_n    = GAP;
            ret_n      = PUSH_SET;
         end
         PUSH_SET: begin
            chipselect = 1'b1;
            write      = 1'b1;
            address    = 2'd3;
            writedata  = 32'h1;
            state_n    = GAP;
            ret_n      = PUSH_CLR;
         end
         PUSH_CLR: begin
            chipselect = 1'b1;
            write      = 1'b1;
            address    = 2'd3;
            state_n    = GAP;
            ret_n      = IDLE;
         end
         START_SET: begin
            chipselect = 1'b1;
            write      = 1'b1;
            address    = 2'd3;
            writedata  = 32'h2;
            state_n    = GAP;
            ret_n      = START_CLR;
         end
         START_CLR: begin
            chipselect = 1'b1;
            write      = 1'b1;
            address    = 2'd3;
            state_n    = GAP;
            ret_n      = IDLE;
         end
         GAP: state_n = ret;
         WAIT: if (cnt == '0) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // DECIDE plus the WAIT cycles and IDLE make polls POLL_GAP+3 apart
   always_ff @(posedge clk) begin
      if (reset) begin
         status     <= '0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         tx_pending <= 1'b0;
         cnt        <= '0;
      end else begin
         if (state == POLL_WAIT) status <= readdata[3:0];
         if (state == RD_WAIT) rx_data <= readdata[DW-1:0];
         if (state == POP_CLR) begin
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
            rx_data  <= '0;
         end
         if (state == TX_DATA) tx_pending <= 1'b1;
         else if (state == START_SET) tx_pending <= 1'b0;
         if (state == DECIDE) cnt <= CW'(LOADV);
         else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_avalon_master.sv
// Scoreboard bench for uart_avalon_master with a behavioural peripheral.
// Bus transactions and RX bytes are checked by a negedge monitor.
module tb_uart_avalon_master;

   localparam int P  = 0;
   localparam int DW = 8;
   localparam int G  = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic [1:0]    address;
   logic          chipselect;
   logic          read;
   logic          write;
   logic [31:0]   writedata;
   logic [31:0]   readdata = 32'd0;

   logic [7:0] status_m;
   logic [7:0] rxbyte_m;

   typedef struct packed {
      logic        wr;
      logic [1:0]  a;
      logic [31:0] d;
   } txn_t;

   txn_t       expq[$];
   logic [7:0] rxq[$];
   int         polls[$];
   int         tests = 0;
   int         fails = 0;
   int         txr_cnt = 0;
   int         cyc = 0;
   logic       prev_cs = 1'b0;
   txn_t       me;
   logic [7:0] mr;

   uart_avalon_master #(.P(P), .POLL_GAP(G)) dut (
      .clk(clk), .reset(reset),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .address(address), .chipselect(chipselect),
      .read(read), .write(write),
      .writedata(writedata), .readdata(readdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // peripheral: read data returned the cycle after the strobe, junk upper bits
   always @(posedge clk) begin
      if (chipselect && read) begin
         if (address == 2'd2) readdata <= {24'hA5A5A5, status_m};
         else if (address == 2'd1) readdata <= {24'h5A5A5A, rxbyte_m};
         else readdata <= 32'd0;
      end else begin
         readdata <= 32'hFFFF_FF00;
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         prev_cs = 1'b0;
      end else begin
         if (prev_cs) begin
            tests++;
            if (chipselect) begin
               fails++;
               $display("FAIL gap: chipselect=%0b required 0", chipselect);
            end
         end
         if (tx_ready) txr_cnt++;
         if (chipselect && !(read && address == 2'd2)) begin
            tests++;
            if (expq.size() == 0) begin
               fails++;
               $display("FAIL unexpected txn: wr=%0b addr=%0d data=%h required none",
                        write, address, writedata);
            end else begin
               me = expq.pop_front();
               if (write != me.wr || read == me.wr || address != me.a ||
                   (me.wr && writedata != me.d)) begin
                  fails++;
                  $display("FAIL txn: wr=%0b addr=%0d data=%h required wr=%0b addr=%0d data=%h",
                           write, address, writedata, me.wr, me.a, me.d);
               end
            end
         end
         if (chipselect && read && address == 2'd2) polls.push_back(cyc);
         prev_cs = chipselect;
         if (rx_valid && rx_ready) begin
            tests++;
            if (rxq.size() == 0) begin
               fails++;
               $display("FAIL rx unexpected: got %h required none", rx_data);
            end else begin
               mr = rxq.pop_front();
               if (rx_data != mr) begin
                  fails++;
                  $display("FAIL rx byte: got %h required %h", rx_data, mr);
               end
            end
         end
      end
   end

   task automatic check(input string n, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h", n, act, exp);
      end
   endtask

   task automatic push_w(input logic [1:0] a, input logic [31:0] d);
      txn_t t;
      t.wr = 1'b1;
      t.a  = a;
      t.d  = d;
      expq.push_back(t);
   endtask

   task automatic push_r(input logic [1:0] a);
      txn_t t;
      t.wr = 1'b0;
      t.a  = a;
      t.d  = 32'd0;
      expq.push_back(t);
   endtask

   task automatic wait_drain(input string n);
      for (int i = 0; i < 300; i++) begin
         if (expq.size() == 0) break;
         @(posedge clk);
      end
      check({n, " drain"}, expq.size(), 0);
   endtask

   task automatic wait_tx_ready(input string n);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (tx_ready) break;
      end
      check({n, " tx_ready seen"}, tx_ready, 1);
   endtask

   task automatic send_tx(input logic [7:0] b, input string n);
      tx_data  = b;
      tx_valid = 1'b1;
      wait_tx_ready(n);
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   int t0;

   initial begin
      reset    = 1'b1;
      tx_valid = 1'b0;
      tx_data  = '0;
      rx_ready = 1'b0;
      status_m = 8'h0A;
      rxbyte_m = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset cs", chipselect, 0);
      check("reset rd/wr", {read, write}, 0);
      check("reset tx_ready", tx_ready, 0);
      check("reset rx_valid", rx_valid, 0);
      check("reset addr/wd", {address, writedata}, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      // push 0x5A then START once tx_valid drops
      t0 = txr_cnt;
      push_w(2'd0, 32'h5A);
      push_w(2'd3, 32'h1);
      push_w(2'd3, 32'h0);
      push_w(2'd3, 32'h2);
      push_w(2'd3, 32'h0);
      send_tx(8'h5A, "tx5a");
      wait_drain("tx5a");
      repeat (3 * (G + 3)) @(posedge clk);
      check("tx5a tx_ready cycles", txr_cnt - t0, 1);

      // RX byte 0xC3
      push_r(2'd1);
      push_w(2'd3, 32'h4);
      push_w(2'd3, 32'h0);
      rxq.push_back(8'hC3);
      rxbyte_m = 8'hC3;
      status_m = 8'h02;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (rx_valid) break;
      end
      check("rx_valid set", rx_valid, 1);
      check("rx_data", rx_data, 32'hC3);
      wait_drain("rx pop");

      // held RX blocks further reads; TX proceeds
      push_w(2'd0, 32'h11);
      push_w(2'd3, 32'h1);
      push_w(2'd3, 32'h0);
      push_w(2'd3, 32'h2);
      push_w(2'd3, 32'h0);
      send_tx(8'h11, "tx11");
      wait_drain("tx11");
      @(negedge clk);
      check("rx_valid held", rx_valid, 1);
      check("rx_data held", rx_data, 32'hC3);
      status_m = 8'h0A;
      repeat (3 * (G + 3)) @(posedge clk);
      #1 rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
      @(negedge clk);
      check("rx_valid cleared", rx_valid, 0);
      check("rx queue empty", rxq.size(), 0);

      // full_tx with tx_pending: START only, no push
      push_w(2'd0, 32'h77);
      push_w(2'd3, 32'h1);
      push_w(2'd3, 32'h0);
      push_w(2'd3, 32'h2);
      push_w(2'd3, 32'h0);
      tx_data  = 8'h77;
      tx_valid = 1'b1;
      wait_tx_ready("tx77");
      status_m = 8'h09;
      @(posedge clk);
      #1 tx_data = 8'h88;
      t0 = txr_cnt;
      wait_drain("full start");
      repeat (3 * (G + 3)) @(posedge clk);
      check("full tx_ready cycles", txr_cnt - t0, 0);
      tx_valid = 1'b0;
      status_m = 8'h0A;

      // idle poll spacing
      repeat (10) @(posedge clk);
      polls.delete();
      for (int i = 0; i < 300; i++) begin
         if (polls.size() >= 4) break;
         @(posedge clk);
      end
      check("poll count", polls.size() >= 4, 1);
      if (polls.size() >= 4) begin
         for (int i = 1; i < 4; i++)
            check("poll spacing", polls[i] - polls[i-1], G + 3);
      end

      // reset in the middle of PUSH_SET
      push_w(2'd0, 32'h5A);
      push_w(2'd3, 32'h1);
      tx_data  = 8'h5A;
      tx_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (write && address == 2'd3 && writedata == 32'h1) break;
      end
      check("push_set seen", {write, address, writedata}, {1'b1, 2'd3, 32'h1});
      reset    = 1'b1;
      tx_valid = 1'b0;
      @(negedge clk);
      check("rst cs/wr", {chipselect, write}, 0);
      check("rst tx_ready", tx_ready, 0);
      check("rst rx_valid", rx_valid, 0);
      repeat (2) @(posedge clk);
      expq.delete();
      #1 reset = 1'b0;
      repeat (3 * (G + 3)) @(posedge clk);
      check("post reset no txn", expq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
